// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: command sequencer for the 2D convolution datapath (kernel regs, column BRAMs, address FSM, convolver).
// Optional RUN watchdog: define CONV_SEQ_WDOG_EN to abort a RUN that sees no i_eop within WDOG_CYC cycles.
module conv_seq_ctrl #(
    parameter int BIT_LEN   = 8,
    parameter int RAM_WIDTH = 13,
    parameter int NB_IMAGE  = 10,
    parameter int MIN_LEN   = 3,
    parameter int WDOG_CYC  = 4096
) (
    input  logic                 i_CLK,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [2:0]           i_cmd_op,
    input  logic [3*BIT_LEN-1:0] i_cmd_data,
    input  logic                 i_eop,
    output logic                 o_rst_conv,
    output logic                 o_rst_fsm,
    output logic                 o_k_i,
    output logic [3*BIT_LEN-1:0] o_kdata,
    output logic                 o_sop,
    output logic                 o_valid_fsm,
    output logic [1:0]           o_sel,
    output logic                 o_load,
    output logic [RAM_WIDTH-1:0] o_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_DONE} state_t;
    localparam logic [2:0] OP_SET_LEN = 3'd1;
    localparam logic [2:0] OP_KERNEL  = 3'd2;
    localparam logic [2:0] OP_PIXEL   = 3'd3;
    localparam logic [2:0] OP_RUN     = 3'd4;
    localparam logic [2:0] OP_ABORT   = 3'd5;
`ifdef CONV_SEQ_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    state_t              r_state;
    logic [1:0]          r_init_cnt;
    logic [1:0]          r_kcnt;
    logic [1:0]          r_bank;
    logic [NB_IMAGE-1:0] r_len;
    logic [NB_IMAGE-1:0] r_pix;
    logic                r_len_ok;
    logic [31:0]         r_wdog;
    logic                w_acc;
    logic                w_abort;
    logic [NB_IMAGE-1:0] w_len;
    logic                w_pix_last;
    logic                w_run_ok;
    logic                w_wdog_exp;
    logic                w_go_init;
    assign w_acc      = i_cmd_valid & o_cmd_ready;
    assign w_abort    = w_acc && i_cmd_op == OP_ABORT;
    assign w_len      = i_cmd_data[NB_IMAGE-1:0];
    assign w_pix_last = r_pix == r_len - NB_IMAGE'(1);
    assign w_run_ok   = r_kcnt == 2'd3 && r_bank == 2'd3 && r_len_ok;
    assign w_wdog_exp = WDOG_EN && r_wdog == 32'(WDOG_CYC - 1);
    // ABORT (IDLE or RUN) and an expired watchdog both restart the INIT reset hold; ABORT beats i_eop
    assign w_go_init  = ((r_state == S_IDLE || r_state == S_RUN) && w_abort)
                      || (r_state == S_RUN && w_wdog_exp && !i_eop);
    // Sequencer FSM: all datapath controls are registered here, pulses default low every cycle
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            r_state     <= S_INIT;
            r_init_cnt  <= 2'd0;
            r_kcnt      <= 2'd0;
            r_bank      <= 2'd0;
            r_len       <= '0;
            r_pix       <= '0;
            r_len_ok    <= 1'b0;
            r_wdog      <= '0;
            o_cmd_ready <= 1'b0;
            o_rst_conv  <= 1'b1;
            o_rst_fsm   <= 1'b1;
            o_k_i       <= 1'b0;
            o_kdata     <= '0;
            o_sop       <= 1'b0;
            o_valid_fsm <= 1'b0;
            o_sel       <= 2'b00;
            o_load      <= 1'b0;
            o_wdata     <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_sop     <= 1'b0;
            o_load    <= 1'b0;
            o_done    <= 1'b0;
            o_rst_fsm <= 1'b0;
            case (r_state)
                S_INIT: begin
                    o_rst_fsm  <= r_init_cnt != 2'd2;
                    r_init_cnt <= r_init_cnt + 2'd1;
                    if (r_init_cnt == 2'd2) begin
                        r_state     <= S_IDLE;
                        o_rst_conv  <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                S_IDLE: if (w_acc) case (i_cmd_op)
                    OP_SET_LEN: if (w_len < NB_IMAGE'(MIN_LEN)) o_err <= 1'b1;
                    else begin
                        r_len     <= w_len;
                        r_len_ok  <= 1'b1;
                        o_wdata   <= RAM_WIDTH'(w_len);
                        o_rst_fsm <= 1'b1;
                        r_pix     <= '0;
                        r_bank    <= 2'd0;
                        r_kcnt    <= 2'd0;
                        o_err     <= 1'b0;
                    end
                    OP_KERNEL: if (r_kcnt == 2'd3) o_err <= 1'b1;
                    else begin
                        o_kdata <= i_cmd_data;
                        o_k_i   <= 1'b0;
                        r_kcnt  <= r_kcnt + 2'd1;
                    end
                    OP_PIXEL: if (r_bank == 2'd3) o_err <= 1'b1;
                    else begin
                        o_sel   <= r_bank + 2'd1;
                        o_wdata <= i_cmd_data[RAM_WIDTH-1:0];
                        o_load  <= 1'b1;
                        r_pix   <= w_pix_last ? '0 : r_pix + NB_IMAGE'(1);
                        r_bank  <= r_bank + {1'b0, w_pix_last};
                    end
                    OP_RUN: if (!w_run_ok) o_err <= 1'b1;
                    else begin
                        r_state     <= S_RUN;
                        o_sel       <= 2'b00;
                        o_k_i       <= 1'b1;
                        o_sop       <= 1'b1;
                        o_valid_fsm <= 1'b1;
                        o_busy      <= 1'b1;
                        r_wdog      <= 32'd1;
                    end
                    default: ;
                endcase
                S_RUN: begin
                    r_wdog <= r_wdog + 32'd1;
                    if (w_acc && i_cmd_op != OP_ABORT) o_err <= 1'b1;
                    if (i_eop) begin
                        r_state     <= S_DONE;
                        o_valid_fsm <= 1'b0;
                        o_done      <= 1'b1;
                        o_cmd_ready <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    r_kcnt      <= 2'd0;
                    r_bank      <= 2'd0;
                    r_pix       <= '0;
                end
            endcase
            if (w_go_init) begin
                r_state     <= S_INIT;
                r_init_cnt  <= 2'd1;
                o_cmd_ready <= 1'b0;
                o_rst_conv  <= 1'b1;
                o_rst_fsm   <= 1'b1;
                o_valid_fsm <= 1'b0;
                o_sop       <= 1'b0;
                o_done      <= 1'b0;
                o_sel       <= 2'b00;
                o_k_i       <= 1'b0;
                o_busy      <= 1'b1;
                if (!w_abort) o_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: table-driven and sequence checks of conv_seq_ctrl with an expected-output scoreboard
module tb_conv_seq_ctrl;
    localparam logic [2:0] OP_NOP = 3'd0, OP_SET_LEN = 3'd1, OP_KERNEL = 3'd2;
    localparam logic [2:0] OP_PIXEL = 3'd3, OP_RUN = 3'd4, OP_ABORT = 3'd5;
    typedef struct packed {
        logic        ready, busy, rst_conv, rst_fsm, k_i, sop, valid, load, done, err;
        logic [1:0]  sel;
        logic [23:0] kdata;
        logic [12:0] wdata;
    } exp_t;
    typedef struct packed {
        logic [2:0]  op;
        logic [23:0] d;
        logic        ld, rf, er;
        logic [1:0]  sel;
        logic [23:0] kd;
        logic [12:0] wd;
    } vec_t;
    logic        clk = 1'b0;
    logic        i_reset, i_cmd_valid, i_eop;
    logic [2:0]  i_cmd_op;
    logic [23:0] i_cmd_data;
    logic        o_cmd_ready, o_rst_conv, o_rst_fsm, o_k_i, o_sop, o_valid_fsm, o_load, o_busy, o_done, o_err;
    logic [23:0] o_kdata;
    logic [1:0]  o_sel;
    logic [12:0] o_wdata;
    int          n_vec = 0, n_mis = 0;
    exp_t        m;
    exp_t        sbq[$];
    string       nmq[$];
    vec_t        tbl[$];

    conv_seq_ctrl #(.WDOG_CYC(64)) dut (
        .i_CLK(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data), .i_eop(i_eop), .o_rst_conv(o_rst_conv),
        .o_rst_fsm(o_rst_fsm), .o_k_i(o_k_i), .o_kdata(o_kdata), .o_sop(o_sop),
        .o_valid_fsm(o_valid_fsm), .o_sel(o_sel), .o_load(o_load), .o_wdata(o_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [2:0] op, input logic [23:0] d, input logic ld, input logic rf,
                               input logic er, input logic [1:0] sel, input logic [23:0] kd, input logic [12:0] wd);
        v = '{op, d, ld, rf, er, sel, kd, wd};
    endfunction

    task automatic pop_chk();
        exp_t  e = sbq.pop_front();
        string nm = nmq.pop_front();
        exp_t  a;
        a = {o_cmd_ready, o_busy, o_rst_conv, o_rst_fsm, o_k_i, o_sop, o_valid_fsm, o_load, o_done, o_err,
             o_sel, o_kdata, o_wdata};
        n_vec++;
        if (a !== e) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    // drive one cycle of inputs from a negedge, then compare the outputs one edge later
    task automatic cyc(input logic vld, input logic [2:0] op, input logic [23:0] d, input string nm);
        i_cmd_valid = vld;
        i_cmd_op    = op;
        i_cmd_data  = d;
        sbq.push_back(m);
        nmq.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        pop_chk();
    endtask

    task automatic idle_exp();
        m.ready = 1'b1; m.busy = 1'b0; m.rst_conv = 1'b0; m.rst_fsm = 1'b0;
    endtask

    task automatic init_exp();
        m.ready = 1'b0; m.busy = 1'b1; m.rst_conv = 1'b1; m.rst_fsm = 1'b1;
        m.k_i = 1'b0; m.sel = 2'b00; m.valid = 1'b0; m.sop = 1'b0; m.done = 1'b0;
    endtask

    task automatic load(input bit setlen, input int len, input int nk, input int np);
        logic [23:0] d;
        if (setlen) begin
            m.rst_fsm = 1'b1; m.err = 1'b0; m.wdata = 13'(len);
            cyc(1'b1, OP_SET_LEN, 24'(len), "set_len");
            m.rst_fsm = 1'b0;
        end
        for (int j = 0; j < nk; j++) begin
            d = {8'(j + 1), 8'(j + 2), 8'(j + 3)};
            m.kdata = d; m.k_i = 1'b0;
            cyc(1'b1, OP_KERNEL, d, $sformatf("kernel%0d", j));
        end
        for (int i = 0; i < np; i++) begin
            d = 24'(i * 3 + 1);
            m.load = 1'b1; m.sel = 2'(1 + i / len); m.wdata = 13'(d);
            cyc(1'b1, OP_PIXEL, d, $sformatf("pixel%0d", i));
        end
        m.load = 1'b0;
    endtask

    task automatic run_start(input string nm);
        m.sop = 1'b1; m.valid = 1'b1; m.k_i = 1'b1; m.sel = 2'b00; m.busy = 1'b1; m.ready = 1'b1;
        cyc(1'b1, OP_RUN, 24'd0, nm);
        m.sop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back(v(OP_SET_LEN, 24'hFFFC0A, 1'b0, 1'b1, 1'b0, 2'd0, 24'h0, 13'd10));
        tbl.push_back(v(OP_KERNEL, 24'h010203, 1'b0, 1'b0, 1'b0, 2'd0, 24'h010203, 13'd10));
        tbl.push_back(v(OP_KERNEL, 24'h040506, 1'b0, 1'b0, 1'b0, 2'd0, 24'h040506, 13'd10));
        tbl.push_back(v(OP_KERNEL, 24'h070809, 1'b0, 1'b0, 1'b0, 2'd0, 24'h070809, 13'd10));
        for (int i = 0; i < 30; i++)
            tbl.push_back(v(OP_PIXEL, 24'hFFE000 + 24'(i), 1'b1, 1'b0, 1'b0, 2'(1 + i / 10), 24'h070809, 13'(i)));
        tbl.push_back(v(OP_PIXEL, 24'd99, 1'b0, 1'b0, 1'b1, 2'd3, 24'h070809, 13'd29));
        tbl.push_back(v(OP_KERNEL, 24'h0A0B0C, 1'b0, 1'b0, 1'b1, 2'd3, 24'h070809, 13'd29));
        tbl.push_back(v(OP_SET_LEN, 24'd2, 1'b0, 1'b0, 1'b1, 2'd3, 24'h070809, 13'd29));
        tbl.push_back(v(OP_NOP, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 2'd3, 24'h070809, 13'd29));

        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = OP_NOP; i_cmd_data = '0; i_eop = 1'b0;
        m = '{ready: 1'b0, busy: 1'b1, rst_conv: 1'b1, rst_fsm: 1'b1, k_i: 1'b0, sop: 1'b0, valid: 1'b0,
              load: 1'b0, done: 1'b0, err: 1'b0, sel: 2'b00, kdata: 24'h0, wdata: 13'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        sbq.push_back(m); nmq.push_back("reset_vals");
        pop_chk();
        i_reset = 1'b0;
        cyc(1'b0, OP_NOP, 24'd0, "init_hold1");
        cyc(1'b0, OP_NOP, 24'd0, "init_hold2");
        idle_exp();
        cyc(1'b0, OP_NOP, 24'd0, "init_release");

        foreach (tbl[i]) begin
            m.load = tbl[i].ld; m.rst_fsm = tbl[i].rf; m.err = tbl[i].er;
            m.sel = tbl[i].sel; m.kdata = tbl[i].kd; m.wdata = tbl[i].wd;
            cyc(1'b1, tbl[i].op, tbl[i].d, $sformatf("vec%0d_op%0d", i, tbl[i].op));
        end
        m.load = 1'b0; m.rst_fsm = 1'b0;

        run_start("run1_c1");
        for (int k = 2; k <= 50; k++) cyc(1'b0, OP_NOP, 24'd0, $sformatf("run1_c%0d", k));
        i_eop = 1'b1;
        m.valid = 1'b0; m.done = 1'b1; m.ready = 1'b0;
        cyc(1'b0, OP_NOP, 24'd0, "run1_done");
        i_eop = 1'b0;
        m.done = 1'b0;
        idle_exp();
        cyc(1'b0, OP_NOP, 24'd0, "run1_idle");

        load(1'b0, 10, 3, 30);
        run_start("run2_c1");
        cyc(1'b0, OP_NOP, 24'd0, "run2_c2");
        i_eop = 1'b1;
        init_exp();
        cyc(1'b1, OP_ABORT, 24'd0, "abort_eop");
        i_eop = 1'b0;
        cyc(1'b0, OP_NOP, 24'd0, "abort_hold2");
        idle_exp();
        cyc(1'b0, OP_NOP, 24'd0, "abort_idle");
        i_eop = 1'b1;
        cyc(1'b0, OP_NOP, 24'd0, "eop_in_idle");
        i_eop = 1'b0;

        load(1'b1, 3, 2, 0);
        m.err = 1'b1;
        cyc(1'b1, OP_RUN, 24'd0, "run_kcnt2");

        load(1'b1, 3, 3, 9);
        run_start("run3_c1");
        m.err = 1'b1;
        cyc(1'b1, OP_NOP, 24'd0, "run3_cmd_err");
        cyc(1'b0, OP_NOP, 24'd0, "run3_c3");
        i_eop = 1'b1;
        m.valid = 1'b0; m.done = 1'b1; m.ready = 1'b0;
        cyc(1'b0, OP_NOP, 24'd0, "run3_done");
        i_eop = 1'b0;
        m.done = 1'b0;
        idle_exp();
        cyc(1'b0, OP_NOP, 24'd0, "run3_idle");

`ifdef CONV_SEQ_WDOG_EN
        load(1'b1, 3, 3, 9);
        run_start("wdog_c1");
        for (int k = 2; k <= 63; k++) cyc(1'b0, OP_NOP, 24'd0, $sformatf("wdog_c%0d", k));
        init_exp();
        m.err = 1'b1;
        cyc(1'b0, OP_NOP, 24'd0, "wdog_expire");
        cyc(1'b0, OP_NOP, 24'd0, "wdog_hold2");
        idle_exp();
        cyc(1'b0, OP_NOP, 24'd0, "wdog_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Hardware sequencer for the 2D convolution datapath: kernel regs, three column BRAMs, the address FSM and the convolver.
- Takes the control sequencing away from GPIO bit-banging.
- Accepts host commands over a valid/ready handshake and drives conv reset, K/I select, FSM reset/SoP/valid, bank select, load strobe and write data in the required order.
- Sits between the host GPIO bridge and the datapath top.

Parameters:
- BIT_LEN, 8, kernel coefficient width
- RAM_WIDTH, 13, pixel/BRAM word width
- NB_IMAGE, 10, image length field width
- MIN_LEN, 3, smallest legal image length
- WDOG_CYC, 4096, watchdog limit in cycles (optional feature only)

Ports:
- i_CLK  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_op  in  3  opcode: 0 NOP, 1 SET_LEN, 2 KERNEL, 3 PIXEL, 4 RUN, 5 ABORT
- i_cmd_data  in  3*BIT_LEN  payload
- i_eop  in  1  end-of-process from address FSM
- o_rst_conv  out  1  convolver reset
- o_rst_fsm  out  1  address FSM reset (FSM samples length on it)
- o_k_i  out  1  0 = kernel path, 1 = image path
- o_kdata  out  3*BIT_LEN  kernel column {c2,c1,c0}
- o_sop  out  1  start-of-process pulse
- o_valid_fsm  out  1  FSM run enable
- o_sel  out  2  00 = conv writes mem0; 01/10/11 = host writes mem0/1/2
- o_load  out  1  one-cycle write strobe
- o_wdata  out  RAM_WIDTH  length or pixel data
- o_busy  out  1  not in IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky error; cleared by SET_LEN or reset

Behaviour:
- All outputs are registered. A command accepted at edge T shows its effect at T+1.
- Reset values:
  - o_rst_conv = 1, o_rst_fsm = 1, o_k_i = 0, o_sel = 00.
  - o_busy = 1, o_cmd_ready = 0.
  - o_sop, o_load, o_valid_fsm, o_done, o_err = 0.
  - o_kdata, o_wdata = 0.
  - State = INIT.
- INIT:
  - Holds both resets for 2 cycles after i_reset deasserts, then goes to IDLE.
  - Entering IDLE drops both resets and sets o_busy = 0.
- IDLE (o_cmd_ready = 1):
  - SET_LEN:
    - len = data[NB_IMAGE-1:0].
    - If len < MIN_LEN: o_err = 1, command dropped.
    - Otherwise: stores len, o_wdata = len, o_rst_fsm pulses 1 cycle, pixel counter = 0, bank = 0, kernel count = 0, o_err cleared.
  - KERNEL:
    - o_kdata = data, o_k_i = 0.
    - o_rst_conv = 0 and o_valid_fsm = 0 throughout.
    - kcnt increments. A 4th KERNEL before RUN sets o_err and is dropped.
  - PIXEL:
    - o_sel = bank+1, o_wdata = data[RAM_WIDTH-1:0], o_load pulses 1 cycle.
    - pixcnt increments. At pixcnt == len-1 it wraps to 0 and bank advances (0→1→2).
    - A PIXEL after bank 2 is full sets o_err and is dropped.
  - RUN:
    - Legal only when kcnt == 3, all three banks are full and len is set. Otherwise o_err = 1 and the command is dropped.
    - On accept, next state is RUN.
  - NOP: consumed, no effect.
  - ABORT: go to INIT.
- RUN:
  - First cycle: o_sel = 00, o_k_i = 1, o_sop = 1.
  - o_valid_fsm = 1 from the first cycle until i_eop is sampled high.
  - o_cmd_ready stays 1. ABORT goes to INIT. Any other opcode sets o_err and is dropped.
- DONE (1 cycle):
  - o_valid_fsm = 0, o_done = 1.
  - Clears kcnt and bank so a new frame can be loaded. Length is kept.
  - Next state is IDLE.
- Simultaneous events:
  - i_eop and ABORT in the same cycle: ABORT wins, no o_done.
  - i_reset overrides everything in any state, including mid-RUN.
- i_eop outside RUN is ignored.

Optional Feature:
- CONV_SEQ_WDOG_EN defined:
  - RUN has a cycle counter.
  - If i_eop is not seen within WDOG_CYC cycles: o_err = 1, o_valid_fsm drops, state goes to INIT, no o_done.
- Not defined: RUN waits indefinitely for i_eop.

Test Plan:
- Reset held 3 cycles, then released → o_rst_conv and o_rst_fsm stay high 2 more cycles; o_cmd_ready rises on the 3rd cycle after release.
- SET_LEN 10 → o_rst_fsm 1-cycle pulse with o_wdata = 10, o_err = 0. Then SET_LEN 2 → o_err = 1 and stored length stays 10.
- 3 KERNEL cmds (0x010203, 0x040506, 0x070809), then 30 PIXEL cmds (0..29) → o_sel = 01 for pixels 0–9, 10 for 10–19, 11 for 20–29, one o_load per pixel. A 31st PIXEL → o_err.
- RUN after the full load, i_eop driven at cycle 50 → o_sop on cycle 1, o_valid_fsm high cycles 1–50, o_done pulse on cycle 51, back in IDLE on 52.
- RUN with kcnt = 2 → o_err = 1, no o_sop. ABORT mid-RUN → o_valid_fsm drops next cycle, resets reasserted 2 cycles, no o_done.
- With CONV_SEQ_WDOG_EN and WDOG_CYC = 64, RUN with no i_eop → o_err set at cycle 64, state INIT, no o_done.
